riscv_v_reduct_acc: RTL
=======================

# riscv_v_reduct_acc

Multi-beat reduction accumulator sitting directly downstream of the bitwise AND/OR/XOR units in the vector ALU. Each beat delivers a byte-vector result in which the unit has already folded the in-register elements down to element 0. This block combines those per-beat partials across all beats of a `vredand`/`vredor`/`vredxor` and folds in the scalar `vs1[0]`. It then presents one scalar result through a valid/ready handshake.

## Interface
- `NUM_BYTES`, default `RISCV_V_NUM_BYTES_DATA`: bytes per input beat; must be ≥ 8.
- `SCALAR_W`, default 64: width of scalar init and result.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_data`  in  `riscv_v_src_byte_vector_t`  per-beat partial; only bytes 0..osize-1 are used.
- `in_first`  in  1  first beat of a reduction.
- `in_last`  in  1  last beat of a reduction.
- `in_op`  in  `riscv_v_reduct_op_e`  AND/OR/XOR; sampled on the `in_first` beat.
- `in_osize`  in  `osize_vector_t`  one-hot element size: bit0 = 8, bit1 = 16, bit2 = 32, bit3 = 64; sampled on the `in_first` beat.
- `in_scalar`  in  `SCALAR_W`  `vs1[0]`; sampled on the `in_first` beat.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  `SCALAR_W`  result, zero-extended above osize.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM with three states: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready` = 1.
  - An accepted beat with `in_first` latches op and osize, and sets acc = mask(op(in_scalar, elem0)).
  - Next state: DONE if `in_last`, else ACCUM.
  - An accepted beat without `in_first` is discarded; state stays IDLE.
- **ACCUM**
  - `in_ready` = 1.
  - An accepted beat sets acc = mask(op(acc, elem0)), using the latched op and osize.
  - If `in_last`, go to DONE.
  - A beat with `in_first` restarts the reduction: the old acc is discarded and the beat is handled exactly as in IDLE.
- **DONE**
  - `in_ready` = 0, `out_valid` = 1, `out_data` = acc.
  - On `out_ready`, go to IDLE.
- `elem0` is bytes 0..osize-1 of `in_data`. mask() zeroes bits ≥ 8·osize.
- `in_osize` with zero or multiple bits set is treated as 8-bit.
- `in_first & in_last` on the same beat is a single-beat reduction.
- Reset forces IDLE from any state and discards any in-flight reduction.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `busy` = 0, `in_ready` = 1, acc = 0.
- `in_ready` is a function of state only and has no combinational path from `in_valid` or `out_ready`.
- Throughput: one beat per cycle in IDLE/ACCUM.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- `out_data` is held stable while `out_valid & ~out_ready`.
- Back-to-back reductions: after the output handshake the block is in IDLE, and the next `in_first` beat is accepted on the following cycle. Minimum gap is 1 idle cycle.

## Configuration
- Macro: `RISCV_V_REDUCT_ACC_ERR_EN`.
- **Defined:** adds output `proto_err` (1 bit, reset 0).
  - It pulses for 1 cycle, the cycle after a protocol violation is accepted.
  - Violations: a non-first beat accepted in IDLE, or an `in_first` beat accepted in ACCUM.
  - Recovery behaviour is unchanged.
- **Undefined:** the port and its logic are absent; violations are handled silently as described in Operation.

## Structure
- Package `riscv_v_pkg` holds:
  - `riscv_v_reduct_op_e` (2 bits: `REDUCT_AND`=0, `REDUCT_OR`=1, `REDUCT_XOR`=2; 3 is treated as XOR).
  - Existing `osize_vector_t`, `riscv_v_src_byte_vector_t`, `BYTE_WIDTH` and `RISCV_V_NUM_BYTES_DATA`.
- One combinational sub-module, `riscv_v_reduct_acc_combine`:
  - Inputs: op, osize, a, b.
  - Output: mask(op(a, b)).
  - Used by both the first-beat and accumulate paths.
- FSM, acc register and handshake logic stay in the top module.

## Test plan
- XOR, osize 8, scalar 0x5A, beats with byte0 = 0x0F, 0xF0, 0x01 (last) -> `out_data` = 0xA4, `out_valid` 1 cycle after the last beat.
- AND, osize 32, scalar 0xFFFF_FFFF, single beat (first & last), word0 = 0x1234_5678, upper bytes 0xFF -> `out_data` = 0x0000_0000_1234_5678.
- OR, osize 16, scalar 0x0001, 4 beats 0x0010/0x0200/0x3000/0x0000 -> 0x3211.
  - Hold `out_ready` = 0 for 5 cycles: `out_data` stable, `in_ready` = 0.
- Restart: XOR first beat 0xFF, then `in_first` beat with scalar 0x00 and data 0x11 (last) -> result 0x11.
  - With `RISCV_V_REDUCT_ACC_ERR_EN`, `proto_err` pulses once.
- Assert `rst` while in ACCUM -> next cycle `busy` = 0, `in_ready` = 1, `out_valid` = 0.
  - A subsequent OR reduction with scalar 0x80 and data 0x01 -> 0x81.
- Random back-to-back reductions with random `in_valid`/`out_ready` stalls, checked against a scoreboard.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types for the reduction accumulator slice.
package riscv_v_pkg;

  localparam int unsigned BYTE_WIDTH             = 8;
  localparam int unsigned RISCV_V_NUM_BYTES_DATA = 16;

  // One-hot element size: bit0 = 8, bit1 = 16, bit2 = 32, bit3 = 64
  typedef logic [3:0] osize_vector_t;

  typedef logic [RISCV_V_NUM_BYTES_DATA-1:0][BYTE_WIDTH-1:0] riscv_v_src_byte_vector_t;

  // Encoding 3 is not named; consumers treat it as XOR
  typedef enum logic [1:0] {
    REDUCT_AND = 2'd0,
    REDUCT_OR  = 2'd1,
    REDUCT_XOR = 2'd2
  } riscv_v_reduct_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } riscv_v_reduct_state_e;

  // Element size in bytes; malformed (zero or multi-hot) sizes fall back to 8-bit
  function automatic int unsigned osize_bytes(input osize_vector_t osize);
    case (osize)
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_v_reduct_acc_combine.sv
// Combinational reduction step: y = mask(op(a, b)), mask keeps the low 8*osize bits.
module riscv_v_reduct_acc_combine
  import riscv_v_pkg::*;
#(
  parameter int unsigned SCALAR_W = 64
) (
  input  riscv_v_reduct_op_e  op,
  input  osize_vector_t       osize,
  input  logic [SCALAR_W-1:0] a,
  input  logic [SCALAR_W-1:0] b,
  output logic [SCALAR_W-1:0] y
);

  logic [SCALAR_W-1:0] res;
  logic [SCALAR_W-1:0] mask;
  int unsigned         nbits;

  // Apply the bitwise op, then clear everything above the element width
  always_comb begin
    case (op)
      REDUCT_AND: res = a & b;
      REDUCT_OR:  res = a | b;
      default:    res = a ^ b;
    endcase
    nbits = osize_bytes(osize) * BYTE_WIDTH;
    mask  = '0;
    for (int unsigned i = 0; i < SCALAR_W; i++) begin
      mask[i] = (i < nbits);
    end
    y = res & mask;
  end

endmodule

// File: rtl/riscv_v_reduct_acc.sv
// Multi-beat AND/OR/XOR reduction accumulator with valid/ready in and out.
// Optional macro RISCV_V_REDUCT_ACC_ERR_EN adds a proto_err pulse output.
module riscv_v_reduct_acc
  import riscv_v_pkg::*;
#(
  parameter int unsigned NUM_BYTES = RISCV_V_NUM_BYTES_DATA,
  parameter int unsigned SCALAR_W  = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0]  in_data,
  input  logic                                  in_first,
  input  logic                                  in_last,
  input  riscv_v_reduct_op_e                    in_op,
  input  osize_vector_t                         in_osize,
  input  logic [SCALAR_W-1:0]                   in_scalar,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SCALAR_W-1:0]                   out_data,
  output logic                                  busy
`ifdef RISCV_V_REDUCT_ACC_ERR_EN
  , output logic                                proto_err
`endif
);

  localparam int unsigned DATA_W = NUM_BYTES * BYTE_WIDTH;

  riscv_v_reduct_state_e state_q, state_d;
  riscv_v_reduct_op_e    op_q;
  osize_vector_t         osize_q;
  logic [SCALAR_W-1:0]   acc_q;

  logic [DATA_W-1:0]     data_flat;
  logic [SCALAR_W-1:0]   elem_raw;
  logic                  accept;
  logic                  start;
  logic                  accum;
  riscv_v_reduct_op_e    comb_op;
  osize_vector_t         comb_osize;
  logic [SCALAR_W-1:0]   comb_a;
  logic [SCALAR_W-1:0]   comb_y;

  assign data_flat = in_data;

  // Element 0 never exceeds the scalar width, so only the low SCALAR_W bits matter
  if (DATA_W >= SCALAR_W) begin : g_trunc
    assign elem_raw = data_flat[SCALAR_W-1:0];
    if (DATA_W > SCALAR_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^data_flat[DATA_W-1:SCALAR_W];
    end
  end else begin : g_pad
    assign elem_raw = {{(SCALAR_W - DATA_W){1'b0}}, data_flat};
  end

  // A first beat restarts from the scalar in both IDLE and ACCUM; plain beats only fold in ACCUM
  always_comb begin
    accept     = in_valid & in_ready;
    start      = accept & in_first;
    accum      = accept & ~in_first & (state_q == ST_ACCUM);
    comb_op    = start ? in_op     : op_q;
    comb_osize = start ? in_osize  : osize_q;
    comb_a     = start ? in_scalar : acc_q;
  end

  riscv_v_reduct_acc_combine #(
    .SCALAR_W (SCALAR_W)
  ) u_combine (
    .op    (comb_op),
    .osize (comb_osize),
    .a     (comb_a),
    .b     (elem_raw),
    .y     (comb_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = in_last ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (accept && in_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend on state and the accumulator only
  always_comb begin
    in_ready  = (state_q != ST_DONE);
    out_valid = (state_q == ST_DONE);
    out_data  = (state_q == ST_DONE) ? acc_q : '0;
    busy      = (state_q != ST_IDLE);
  end

  // Accumulator and per-reduction op/size capture
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      op_q    <= REDUCT_AND;
      osize_q <= '0;
    end else if (start) begin
      acc_q   <= comb_y;
      op_q    <= in_op;
      osize_q <= in_osize;
    end else if (accum) begin
      acc_q   <= comb_y;
    end
  end

`ifdef RISCV_V_REDUCT_ACC_ERR_EN
  // One-cycle flag for a stray non-first beat in IDLE or a first beat mid-reduction
  always_ff @(posedge clk) begin
    if (rst) proto_err <= 1'b0;
    else     proto_err <= accept & (((state_q == ST_IDLE) & ~in_first) |
                                    ((state_q == ST_ACCUM) & in_first));
  end
`endif

endmodule
